meta_out_sched: RTL and testbench



---
 rtl/meta_out_sched_pkg.sv | 28 ++
 rtl/rr_arbiter_4.sv | 30 +++
 rtl/meta_out_sched.sv | 124 ++++++++++++
 tb/tb_meta_out_sched.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meta_out_sched_pkg.sv
// Shared definitions for the output metadata scheduler: port count, metadata
// word layout and FSM state encoding.
package meta_out_sched_pkg;

   localparam int NUM_PORTS = 4;
   localparam int SLOT_W    = 128;
   localparam int META_W    = 64;

   // Metadata word layout: BUFID [15:0], OUTPORT [39:32], PTP_TYPE [50:48], IS_PTP [55]
   typedef struct packed {
      logic [7:0]  rsvd3;
      logic        is_ptp;
      logic [3:0]  rsvd2;
      logic [2:0]  ptp_type;
      logic [7:0]  rsvd1;
      logic [7:0]  outport;
      logic [15:0] rsvd0;
      logic [15:0] bufid;
   } meta_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_CAP  = 2'd2,
      S_SEND = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin select; the search starts one past the
// last granted port and wraps.
module rr_arbiter_4
   import meta_out_sched_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic [1:0]           last,
   output logic [NUM_PORTS-1:0] gnt,
   output logic [1:0]           gnt_idx,
   output logic                 gnt_any
);

   logic [1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = last + 2'(k);
         if (!gnt_any && req[cand]) begin
            gnt_any   = 1'b1;
            gnt_idx   = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/meta_out_sched.sv
// Pops per-port metadata FIFOs in credit-gated round-robin order and issues
// one buffer-read request at a time on a valid/ready channel.
module meta_out_sched
   import meta_out_sched_pkg::*;
#(
   parameter int CREDITS = 4
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   empty_metadata,
   input  logic [511:0] data_metadata,
   output logic [3:0]   rden_metadata,
   output logic         req_valid,
   input  logic         req_ready,
   output logic [15:0]  req_bufid,
   output logic [1:0]   req_port,
   output logic [2:0]   req_ptp_type,
   output logic         req_is_ptp,
   input  logic [3:0]   tx_done,
   output logic [63:0]  cnt_grant
);

   state_t                       state, state_nxt;
   logic [NUM_PORTS-1:0][3:0]    credit;
   logic [NUM_PORTS-1:0][15:0]   cnt;
   logic [1:0]                   last, gnt;
   logic [NUM_PORTS-1:0]         elig, arb_onehot, dec;
   logic [1:0]                   arb_idx;
   logic                         arb_any;
   logic                         do_grant, do_cap;
   meta_t                        word;

   // Grant-decrement and tx_done on the same port cancel; returns saturate.
   function automatic logic [3:0] next_credit(input logic [3:0] c,
                                              input logic dec_i,
                                              input logic inc_i);
      if (inc_i && !dec_i)
         return (c >= 4'(CREDITS)) ? c : c + 4'd1;
      if (dec_i && !inc_i)
         return c - 4'd1;
      return c;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++)
         elig[i] = !empty_metadata[i] && (credit[i] != 4'd0);
   end

   rr_arbiter_4 u_arb (
      .req     (elig),
      .last    (last),
      .gnt     (arb_onehot),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   assign word = meta_t'(data_metadata[{gnt, 7'd0} +: META_W]);

   wire unused_fields = ^{word.rsvd3, word.rsvd2, word.rsvd1, word.outport, word.rsvd0};

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (arb_any) state_nxt = S_RD;
         S_RD:    state_nxt = S_CAP;
         S_CAP:   state_nxt = S_SEND;
         S_SEND:  if (req_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // output / control decode
   always_comb begin
      do_grant  = (state == S_IDLE) && arb_any;
      do_cap    = (state == S_CAP);
      dec       = do_grant ? arb_onehot : '0;
      req_valid = (state == S_SEND);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rden_metadata <= '0;
         gnt           <= '0;
         last          <= 2'd3;
         cnt           <= '0;
         req_bufid     <= '0;
         req_port      <= '0;
         req_ptp_type  <= '0;
         req_is_ptp    <= 1'b0;
      end else begin
         // Pop strobe lands in RD, one cycle after the IDLE grant.
         rden_metadata <= dec;
         if (do_grant) begin
            gnt          <= arb_idx;
            last         <= arb_idx;
            cnt[arb_idx] <= cnt[arb_idx] + 16'd1;
         end
         if (do_cap) begin
            req_bufid    <= word.bufid;
            req_port     <= gnt;
            req_ptp_type <= word.ptp_type;
            req_is_ptp   <= word.is_ptp;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (rst) credit[i] <= 4'(CREDITS);
         else     credit[i] <= next_credit(credit[i], dec[i], tx_done[i]);
      end
   end

   assign cnt_grant = cnt;

endmodule

// File: tb/tb_meta_out_sched.sv
// Randomized and directed bench for meta_out_sched against a transaction-level
// model of credits, round-robin order and request timing.
module tb_meta_out_sched;

   localparam int CREDITS = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   empty_metadata = 4'hf;
   logic [511:0] data_metadata = '0;
   logic [3:0]   rden_metadata;
   logic         req_valid;
   logic         req_ready = 1'b0;
   logic [15:0]  req_bufid;
   logic [1:0]   req_port;
   logic [2:0]   req_ptp_type;
   logic         req_is_ptp;
   logic [3:0]   tx_done = 4'h0;
   logic [63:0]  cnt_grant;

   meta_out_sched #(.CREDITS(CREDITS)) dut (
      .clk            (clk),
      .rst            (rst),
      .empty_metadata (empty_metadata),
      .data_metadata  (data_metadata),
      .rden_metadata  (rden_metadata),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_bufid      (req_bufid),
      .req_port       (req_port),
      .req_ptp_type   (req_ptp_type),
      .req_is_ptp     (req_is_ptp),
      .tx_done        (tx_done),
      .cnt_grant      (cnt_grant)
   );

   always #5 clk = ~clk;

   logic [63:0] q [4][$];

   int          checks = 0;
   int          errors = 0;

   int          m_credit [4];
   int          m_cnt [4];
   int          m_last;
   bit          m_busy;
   int          m_age;
   int          m_g;
   logic [63:0] m_word;
   logic [15:0] e_bufid;
   logic [1:0]  e_port;
   logic [2:0]  e_ptp;
   logic        e_isptp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk_word(input logic [15:0] bufid, input logic [2:0] ptp,
                                           input logic isptp);
      logic [63:0] w;
      w = {$urandom, $urandom};
      w[15:0]  = bufid;
      w[50:48] = ptp;
      w[55]    = isptp;
      return w;
   endfunction

   task automatic push(input int p, input logic [63:0] w);
      q[p].push_back(w);
      empty_metadata[p] = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_credit[i] = CREDITS;
         m_cnt[i]    = 0;
      end
      m_last  = 3;
      m_busy  = 0;
      m_age   = 0;
      m_g     = 0;
      e_bufid = '0;
      e_port  = '0;
      e_ptp   = '0;
      e_isptp = 1'b0;
   endtask

   // Advance the model across the coming clock edge using the inputs now applied.
   task automatic model_step();
      int dec [4];
      bit found;
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 4; i++) dec[i] = 0;
      if (m_busy) begin
         if (m_age >= 3) begin
            if (req_ready) m_busy = 0;
         end else begin
            m_age++;
            if (m_age == 3) begin
               e_bufid = m_word[15:0];
               e_ptp   = m_word[50:48];
               e_isptp = m_word[55];
               e_port  = 2'(m_g);
            end
         end
      end else begin
         found = 0;
         for (int k = 1; k <= 4; k++) begin
            int p;
            p = (m_last + k) % 4;
            if (!found && q[p].size() != 0 && m_credit[p] != 0) begin
               found    = 1;
               m_g      = p;
               m_last   = p;
               m_word   = q[p][0];
               m_busy   = 1;
               m_age    = 1;
               dec[p]   = 1;
               m_cnt[p] = (m_cnt[p] + 1) % 65536;
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         int n;
         n = m_credit[i] - dec[i] + int'(tx_done[i]);
         m_credit[i] = (n > CREDITS) ? CREDITS : n;
      end
   endtask

   task automatic compare_all();
      logic [3:0] er;
      er = (m_busy && m_age == 1) ? 4'(1 << m_g) : 4'd0;
      chk("rden", rden_metadata, er);
      chk("req_valid", req_valid, m_busy && m_age >= 3);
      chk("req_bufid", req_bufid, e_bufid);
      chk("req_port", req_port, e_port);
      chk("req_ptp_type", req_ptp_type, e_ptp);
      chk("req_is_ptp", req_is_ptp, e_isptp);
      chk("cnt_grant", cnt_grant, {16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])});
   endtask

   // One clock: model step, edge, FIFO pops (standard-read dout), check outputs.
   task automatic tick();
      logic [3:0]  r;
      logic [63:0] w;
      r = rden_metadata;
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (r[i] === 1'b1) begin
            chk("pop_nonempty", q[i].size() != 0, 1);
            if (q[i].size() != 0) begin
               w = q[i].pop_front();
               data_metadata[i*128 +: 64]    = w;
               data_metadata[i*128+64 +: 64] = {$urandom, $urandom};
            end
            empty_metadata[i] = (q[i].size() == 0);
         end
      end
      tx_done = 4'h0;
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) q[i].delete();
      empty_metadata = 4'hf;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      @(negedge clk);

      // reset and first request latency
      do_reset();
      req_ready = 1'b1;
      push(0, mk_word(16'h0012, 3'd2, 1'b1));
      tick();
      chk("s1_rden", rden_metadata, 4'b0001);
      tick();
      tick();
      chk("s1_valid", req_valid, 1'b1);
      chk("s1_bufid", req_bufid, 16'h0012);
      chk("s1_ptp", req_ptp_type, 3'd2);
      repeat (3) tick();

      // round-robin 0,1,2,3,0
      do_reset();
      push(0, mk_word(16'h0100, 3'd0, 1'b0));
      push(1, mk_word(16'h0101, 3'd1, 1'b0));
      push(2, mk_word(16'h0102, 3'd3, 1'b1));
      push(3, mk_word(16'h0103, 3'd7, 1'b0));
      push(0, mk_word(16'h0104, 3'd5, 1'b1));
      repeat (20) tick();
      chk("rr_cnt", cnt_grant, {16'd1, 16'd1, 16'd1, 16'd2});
      repeat (4) tick();

      // credit exhaustion on port 2
      do_reset();
      for (int i = 0; i < 6; i++) push(2, mk_word(16'(16'h0200 + i), 3'(i), 1'b1));
      repeat (30) tick();
      chk("cred_exhaust", cnt_grant[47:32], 16'd4);
      tx_done[2] = 1'b1;
      repeat (12) tick();
      chk("cred_return", cnt_grant[47:32], 16'd5);
      repeat (8) tick();
      chk("cred_hold", cnt_grant[47:32], 16'd5);

      // backpressure
      do_reset();
      req_ready = 1'b0;
      push(1, mk_word(16'hbeef, 3'd4, 1'b1));
      repeat (3) tick();
      push(3, mk_word(16'h0333, 3'd1, 1'b0));
      repeat (10) tick();
      chk("bp_valid", req_valid, 1'b1);
      chk("bp_bufid", req_bufid, 16'hbeef);
      req_ready = 1'b1;
      tick();
      chk("bp_idle", req_valid, 1'b0);
      repeat (6) tick();

      // simultaneous credit events
      do_reset();
      tx_done[3] = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) push(1, mk_word(16'(16'h0500 + i), 3'd0, 1'b0));
      tx_done[1] = 1'b1;
      tick();
      repeat (30) tick();
      chk("sim_p1", cnt_grant[31:16], 16'd5);
      for (int i = 0; i < 5; i++) push(3, mk_word(16'(16'h0600 + i), 3'd6, 1'b1));
      repeat (30) tick();
      chk("sat_p3", cnt_grant[63:48], 16'd4);

      // reset in CAP
      do_reset();
      push(0, mk_word(16'h0777, 3'd3, 1'b1));
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_valid", req_valid, 1'b0);
      chk("mr_cnt", cnt_grant, 64'd0);
      for (int i = 0; i < 5; i++) push(0, mk_word(16'(16'h0800 + i), 3'd1, 1'b0));
      repeat (30) tick();
      chk("mr_credits", cnt_grant[15:0], 16'd4);

      // random traffic
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            int p;
            p = $urandom_range(0, 3);
            if (q[p].size() < 8)
               push(p, mk_word(16'($urandom), 3'($urandom), 1'($urandom)));
         end
         for (int i = 0; i < 4; i++) tx_done[i] = ($urandom_range(0, 9) == 0);
         req_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
